dff_bank_arbiter: RTL and testbench

- Two-requester arbiter that shares one WIDTH-bit flip-flop data register between two writers.
- Arbitrates with round-robin priority, loads the winner's data into the shared register, and returns a one-cycle grant/acknowledge.
- Sits between the lab's requester blocks and the D flip-flop register bank; owns all write sequencing of that bank.

---
 rtl/dff_bank_arbiter.sv | 107 ++++++++++
 tb/tb_dff_bank_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter that sequences writes from two
// requesters into one shared WIDTH-bit register.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   REQ0/REQ1  level write requests, held until the matching grant
//   WDATA0/1   write data, stable while the matching request is high
//   Q          shared register contents
//   GNT0/GNT1  one-cycle acknowledge; the requester's data is in Q
//   BUSY       high while a transaction is in LOAD or DONE
//   OWNER      index of the requester that last wrote Q
//   PROTO_ERR  sticky: selected requester dropped its request before grant
module dff_bank_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] WDATA0,
    input  logic [WIDTH-1:0] WDATA1,
    output logic [WIDTH-1:0] Q,
    output logic             GNT0,
    output logic             GNT1,
    output logic             BUSY,
    output logic             OWNER,
    output logic             PROTO_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             sel_q;
    logic             last_q;
    logic [WIDTH-1:0] q_q;
    logic [1:0]       gnt_q;
    logic             busy_q;
    logic             owner_q;
    logic             perr_q;

    // Requests as a vector so the selected one can be indexed directly.
    logic [1:0] req_c;
    assign req_c = {REQ1, REQ0};

    // Arbitration, register load and grant sequencing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;   // requester 0 wins the first tie
            q_q     <= '0;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (REQ0 || REQ1) begin
                        // On a tie, serve the requester not served last time.
                        if (REQ0 && REQ1) begin
                            sel_q <= ~last_q;
                        end else begin
                            sel_q <= REQ1;
                        end
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    q_q          <= sel_q ? WDATA1 : WDATA0;
                    owner_q      <= sel_q;
                    gnt_q[sel_q] <= 1'b1;
                    // The write completes anyway; only the violation is flagged.
                    if (!req_c[sel_q]) begin
                        perr_q <= 1'b1;
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    last_q  <= sel_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q         = q_q;
    assign GNT0      = gnt_q[0];
    assign GNT1      = gnt_q[1];
    assign BUSY      = busy_q;
    assign OWNER     = owner_q;
    assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_dff_bank_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ0;
    logic             REQ1;
    logic [WIDTH-1:0] WDATA0;
    logic [WIDTH-1:0] WDATA1;
    logic [WIDTH-1:0] Q;
    logic             GNT0;
    logic             GNT1;
    logic             BUSY;
    logic             OWNER;
    logic             PROTO_ERR;

    int total = 0;
    int bad   = 0;

    dff_bank_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ0      (REQ0),
        .REQ1      (REQ1),
        .WDATA0    (WDATA0),
        .WDATA1    (WDATA1),
        .Q         (Q),
        .GNT0      (GNT0),
        .GNT1      (GNT1),
        .BUSY      (BUSY),
        .OWNER     (OWNER),
        .PROTO_ERR (PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; WDATA0 = '0; WDATA1 = '0;
        do_reset();

        // Reset state
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_gnt0", 32'(GNT0), 32'h0);
        chk("rst_gnt1", 32'(GNT1), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_owner", 32'(OWNER), 32'h0);
        chk("rst_perr", 32'(PROTO_ERR), 32'h0);

        // Single write from requester 0
        REQ0 = 1'b1; WDATA0 = 4'hA;
        tick();
        chk("t1_busy_e0", 32'(BUSY), 32'h1);
        chk("t1_gnt0_e0", 32'(GNT0), 32'h0);
        tick();
        chk("t1_q_e1", 32'(Q), 32'hA);
        chk("t1_gnt0_e1", 32'(GNT0), 32'h1);
        chk("t1_gnt1_e1", 32'(GNT1), 32'h0);
        chk("t1_owner_e1", 32'(OWNER), 32'h0);
        REQ0 = 1'b0;
        tick();
        chk("t1_gnt0_e2", 32'(GNT0), 32'h0);
        chk("t1_busy_e2", 32'(BUSY), 32'h0);
        chk("t1_owner_e2", 32'(OWNER), 32'h0);

        // Simultaneous requests after reset: 0 first, then 1
        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; WDATA0 = 4'h3; WDATA1 = 4'hC;
        tick();
        tick();
        chk("t2_gnt0", 32'(GNT0), 32'h1);
        chk("t2_gnt1_a", 32'(GNT1), 32'h0);
        chk("t2_q0", 32'(Q), 32'h3);
        REQ0 = 1'b0;
        tick();
        chk("t2_gnt0_off", 32'(GNT0), 32'h0);
        tick();
        chk("t2_busy_e3", 32'(BUSY), 32'h1);
        chk("t2_gnt1_e3", 32'(GNT1), 32'h0);
        tick();
        chk("t2_gnt1", 32'(GNT1), 32'h1);
        chk("t2_gnt0_b", 32'(GNT0), 32'h0);
        chk("t2_q1", 32'(Q), 32'hC);
        chk("t2_owner", 32'(OWNER), 32'h1);
        REQ1 = 1'b0;
        tick();
        chk("t2_gnt1_off", 32'(GNT1), 32'h0);

        // Both requesters contending: grants at ticks 2,5,8,11 alternating 0,1,0,1
        do_reset();
        REQ0 = 1'b1; REQ1 = 1'b1; WDATA0 = 4'h1; WDATA1 = 4'h2;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("t3_gnt0_c%0d", t), 32'(GNT0), 32'((t == 2) || (t == 8)));
            chk($sformatf("t3_gnt1_c%0d", t), 32'(GNT1), 32'((t == 5) || (t == 11)));
            chk($sformatf("t3_overlap_c%0d", t), 32'(GNT0 & GNT1), 32'h0);
            if (!REQ0) REQ0 = 1'b1;
            if (!REQ1) REQ1 = 1'b1;
            if (GNT0) REQ0 = 1'b0;
            if (GNT1) REQ1 = 1'b0;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        chk("t3_q_last", 32'(Q), 32'h2);
        chk("t3_perr", 32'(PROTO_ERR), 32'h0);
        tick();

        // Requester 1 drops its request during LOAD
        do_reset();
        REQ1 = 1'b1; WDATA1 = 4'h5;
        tick();
        REQ1 = 1'b0;
        chk("t4_perr_pre", 32'(PROTO_ERR), 32'h0);
        tick();
        chk("t4_q", 32'(Q), 32'h5);
        chk("t4_gnt1", 32'(GNT1), 32'h1);
        chk("t4_owner", 32'(OWNER), 32'h1);
        chk("t4_perr", 32'(PROTO_ERR), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4_perr_hold%0d", i), 32'(PROTO_ERR), 32'h1);
        end
        chk("t4_gnt1_off", 32'(GNT1), 32'h0);
        do_reset();
        chk("t4_perr_clr", 32'(PROTO_ERR), 32'h0);

        // Reset during LOAD aborts the write; a fresh transaction then completes
        REQ0 = 1'b1; WDATA0 = 4'hF;
        tick();
        chk("t5_busy_e0", 32'(BUSY), 32'h1);
        RST = 1'b1;
        tick();
        chk("t5_q_rst", 32'(Q), 32'h0);
        chk("t5_gnt0_rst", 32'(GNT0), 32'h0);
        chk("t5_busy_rst", 32'(BUSY), 32'h0);
        RST = 1'b0;
        tick();
        chk("t5_busy_new", 32'(BUSY), 32'h1);
        chk("t5_gnt0_new_e0", 32'(GNT0), 32'h0);
        chk("t5_q_new_e0", 32'(Q), 32'h0);
        tick();
        chk("t5_q_new", 32'(Q), 32'hF);
        chk("t5_gnt0_new", 32'(GNT0), 32'h1);
        REQ0 = 1'b0;
        tick();
        chk("t5_gnt0_off", 32'(GNT0), 32'h0);

        // Q holds with no requests
        REQ0 = 1'b1; WDATA0 = 4'h7;
        tick();
        tick();
        chk("t6_q_wr", 32'(Q), 32'h7);
        REQ0 = 1'b0; WDATA0 = 4'h0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t6_q_%0d", i), 32'(Q), 32'h7);
            chk($sformatf("t6_busy_%0d", i), 32'(BUSY), 32'h0);
            chk($sformatf("t6_gnt0_%0d", i), 32'(GNT0), 32'h0);
            chk($sformatf("t6_gnt1_%0d", i), 32'(GNT1), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
